// File: rtl/rf_access_sequencer.sv
// rf_access_sequencer
//   Initiator-side controller for a dual-read register file. Accepts READ,
//   WRITE, READ_WRITE and CLEAR requests on a valid/ready channel, drives the
//   register file strobes, addresses and write data, and returns captured read
//   data on a valid/ready response channel.
//
// Ports
//   CLK, RST                      clock, synchronous active-low reset
//   REQ_VALID/REQ_READY           request handshake (ready only in idle)
//   REQ_OP                        00 read, 01 write, 10 read-then-write, 11 clear
//   REQ_ADDR_R1/R2, REQ_ADDR_W    request addresses
//   REQ_DATA_W                    request write data
//   RSP_VALID/RSP_READY           response handshake
//   RSP_DATA_R1/R2                captured read data
//   RF_READ, RF_WRITE             register-file strobes (never both high)
//   RF_ADDR_R1/R2, RF_ADDR_W      register-file addresses
//   RF_DATA_W                     register-file write data (0 outside a write op)
//   RF_DATA_R1/R2                 register-file read data (valid while RF_READ)
module rf_access_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [1:0]            REQ_OP,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_W,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_W,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA_R1,
  output logic [DATA_WIDTH-1:0] RSP_DATA_R2,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

  localparam logic [1:0] OpRead      = 2'b00;
  localparam logic [1:0] OpWrite     = 2'b01;
  localparam logic [1:0] OpReadWrite = 2'b10;
  localparam logic [1:0] OpClear     = 2'b11;

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StClear, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
  logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rsp_data_r1_q, rsp_data_r1_d;
  logic [DATA_WIDTH-1:0] rsp_data_r2_q, rsp_data_r2_d;
  logic [ADDR_WIDTH-1:0] rf_addr_r1_q, rf_addr_r1_d;
  logic [ADDR_WIDTH-1:0] rf_addr_r2_q, rf_addr_r2_d;
  logic [ADDR_WIDTH-1:0] rf_addr_w_q, rf_addr_w_d;
  logic [DATA_WIDTH-1:0] rf_data_w_q, rf_data_w_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_w_d      = addr_w_q;
    data_w_d      = data_w_q;
    cnt_d         = cnt_q;
    rsp_data_r1_d = rsp_data_r1_q;
    rsp_data_r2_d = rsp_data_r2_q;
    rf_addr_r1_d  = rf_addr_r1_q;
    rf_addr_r2_d  = rf_addr_r2_q;
    rf_addr_w_d   = rf_addr_w_q;
    // Write data is only non-zero while in the write state.
    rf_data_w_d   = '0;

    case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          op_d     = REQ_OP;
          addr_w_d = REQ_ADDR_W;
          data_w_d = REQ_DATA_W;
          case (REQ_OP)
            OpRead, OpReadWrite: begin
              state_d      = StRead;
              rf_addr_r1_d = REQ_ADDR_R1;
              rf_addr_r2_d = REQ_ADDR_R2;
            end
            OpWrite: begin
              state_d     = StWrite;
              rf_addr_w_d = REQ_ADDR_W;
              rf_data_w_d = REQ_DATA_W;
            end
            OpClear: begin
              state_d     = StClear;
              cnt_d       = '0;
              rf_addr_w_d = '0;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StRead: begin
        rsp_data_r1_d = RF_DATA_R1;
        rsp_data_r2_d = RF_DATA_R2;
        if (op_q == OpReadWrite) begin
          state_d     = StWrite;
          rf_addr_w_d = addr_w_q;
          rf_data_w_d = data_w_q;
        end else begin
          state_d = StResp;
        end
      end
      StWrite: state_d = StResp;
      StClear: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          // Last register written; leave the address parked on it.
          state_d = StResp;
        end else begin
          rf_addr_w_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      StResp: begin
        if (RSP_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= StIdle;
      op_q          <= OpRead;
      addr_w_q      <= '0;
      data_w_q      <= '0;
      cnt_q         <= '0;
      rsp_data_r1_q <= '0;
      rsp_data_r2_q <= '0;
      rf_addr_r1_q  <= '0;
      rf_addr_r2_q  <= '0;
      rf_addr_w_q   <= '0;
      rf_data_w_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_w_q      <= addr_w_d;
      data_w_q      <= data_w_d;
      cnt_q         <= cnt_d;
      rsp_data_r1_q <= rsp_data_r1_d;
      rsp_data_r2_q <= rsp_data_r2_d;
      rf_addr_r1_q  <= rf_addr_r1_d;
      rf_addr_r2_q  <= rf_addr_r2_d;
      rf_addr_w_q   <= rf_addr_w_d;
      rf_data_w_q   <= rf_data_w_d;
    end
  end

  // Strobes decode from the single state register, so they cannot overlap.
  assign REQ_READY   = (state_q == StIdle);
  assign RSP_VALID   = (state_q == StResp);
  assign RF_READ     = (state_q == StRead);
  assign RF_WRITE    = (state_q == StWrite) || (state_q == StClear);
  assign RSP_DATA_R1 = rsp_data_r1_q;
  assign RSP_DATA_R2 = rsp_data_r2_q;
  assign RF_ADDR_R1  = rf_addr_r1_q;
  assign RF_ADDR_R2  = rf_addr_r2_q;
  assign RF_ADDR_W   = rf_addr_w_q;
  assign RF_DATA_W   = rf_data_w_q;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Self-checking bench for rf_access_sequencer: models the register file on
// the RF pins and checks each transaction against a transaction-level model.
module tb_rf_access_sequencer;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [1:0]    REQ_OP;
  logic [AW-1:0] REQ_ADDR_R1, REQ_ADDR_R2, REQ_ADDR_W;
  logic [DW-1:0] REQ_DATA_W;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW-1:0] RSP_DATA_R1, RSP_DATA_R2;
  logic          RF_READ, RF_WRITE;
  logic [AW-1:0] RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [DW-1:0] RF_DATA_W;
  wire  [DW-1:0] RF_DATA_R1, RF_DATA_R2;

  rf_access_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_OP      (REQ_OP),
    .REQ_ADDR_R1 (REQ_ADDR_R1),
    .REQ_ADDR_R2 (REQ_ADDR_R2),
    .REQ_ADDR_W  (REQ_ADDR_W),
    .REQ_DATA_W  (REQ_DATA_W),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_DATA_R1 (RSP_DATA_R1),
    .RSP_DATA_R2 (RSP_DATA_R2),
    .RF_READ     (RF_READ),
    .RF_WRITE    (RF_WRITE),
    .RF_ADDR_R1  (RF_ADDR_R1),
    .RF_ADDR_R2  (RF_ADDR_R2),
    .RF_ADDR_W   (RF_ADDR_W),
    .RF_DATA_W   (RF_DATA_W),
    .RF_DATA_R1  (RF_DATA_R1),
    .RF_DATA_R2  (RF_DATA_R2)
  );

  always #5 CLK = ~CLK;

  // Register file attached to the DUT pins.
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge CLK) if (RF_WRITE) rf_mem[RF_ADDR_W] <= RF_DATA_W;
  assign RF_DATA_R1 = RF_READ ? rf_mem[RF_ADDR_R1] : 'z;
  assign RF_DATA_R2 = RF_READ ? rf_mem[RF_ADDR_R2] : 'z;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe traffic observed per cycle.
  logic [63:0] wq [$];
  logic [63:0] rq [$];
  always @(negedge CLK) begin
    check_eq("rd_wr_exclusive", 64'(RF_READ & RF_WRITE), 64'(0));
    if (!RF_WRITE) check_eq("data_w_idle_zero", 64'(RF_DATA_W), 64'(0));
    if (RF_WRITE) wq.push_back(64'({RF_ADDR_W, RF_DATA_W}));
    if (RF_READ) rq.push_back(64'({RF_ADDR_R1, RF_ADDR_R2}));
  end

  // Transaction-level reference model.
  logic [DW-1:0] ref_mem [NREG];
  logic [DW-1:0] exp_r1, exp_r2;
  logic [1:0]    p_op;
  logic [AW-1:0] p_r1, p_r2, p_w;
  logic [DW-1:0] p_d;

  function automatic int exp_latency(input logic [1:0] op);
    case (op)
      2'b00, 2'b01: return 1;
      2'b10: return 2;
      default: return int'(NREG);
    endcase
  endfunction

  task automatic present(input logic [1:0] op, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] w, input logic [DW-1:0] d, input bit early);
    p_op = op; p_r1 = r1; p_r2 = r2; p_w = w; p_d = d;
    REQ_OP = op; REQ_ADDR_R1 = r1; REQ_ADDR_R2 = r2; REQ_ADDR_W = w; REQ_DATA_W = d;
    REQ_VALID = 1'b1;
    RSP_READY = early;
  endtask

  task automatic accept_and_wait();
    int guard = 0;
    int k = 0;
    while (!REQ_READY && guard < 200) begin
      @(posedge CLK); @(negedge CLK); guard++;
    end
    check_eq("req_ready_wait", 64'(REQ_READY), 64'(1));
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    while (!RSP_VALID && k < 200) begin
      @(posedge CLK); @(negedge CLK); k++;
    end
    check_eq("latency", 64'(k), 64'(exp_latency(p_op)));
    if (p_op == 2'b00 || p_op == 2'b10) begin
      exp_r1 = ref_mem[p_r1];
      exp_r2 = ref_mem[p_r2];
      check_eq("read_count", 64'(rq.size()), 64'(1));
      if (rq.size() > 0) check_eq("read_addrs", rq[0], 64'({p_r1, p_r2}));
    end else begin
      check_eq("read_count", 64'(rq.size()), 64'(0));
    end
    if (p_op == 2'b01 || p_op == 2'b10) begin
      check_eq("write_count", 64'(wq.size()), 64'(1));
      if (wq.size() > 0) check_eq("write_beat", wq[0], 64'({p_w, p_d}));
      ref_mem[p_w] = p_d;
    end else if (p_op == 2'b11) begin
      check_eq("clear_count", 64'(wq.size()), 64'(NREG));
      for (int i = 0; i < wq.size(); i++)
        check_eq("clear_beat", wq[i], 64'({AW'(i), DW'(0)}));
      for (int i = 0; i < int'(NREG); i++) ref_mem[i] = '0;
    end else begin
      check_eq("write_count", 64'(wq.size()), 64'(0));
    end
    rq.delete();
    wq.delete();
    check_eq("rsp_data_r1", 64'(RSP_DATA_R1), 64'(exp_r1));
    check_eq("rsp_data_r2", 64'(RSP_DATA_R2), 64'(exp_r2));
    check_eq("req_ready_busy", 64'(REQ_READY), 64'(0));
  endtask

  task automatic release_rsp(input int stall);
    for (int i = 0; i < stall; i++) begin
      RSP_READY = 1'b0;
      @(posedge CLK); @(negedge CLK);
      check_eq("stall_rsp_valid", 64'(RSP_VALID), 64'(1));
      check_eq("stall_rsp_r1", 64'(RSP_DATA_R1), 64'(exp_r1));
      check_eq("stall_req_ready", 64'(REQ_READY), 64'(0));
      check_eq("stall_no_strobe", 64'(rq.size() + wq.size()), 64'(0));
    end
    RSP_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RSP_READY = 1'b0;
    check_eq("post_rsp_valid", 64'(RSP_VALID), 64'(0));
    check_eq("post_req_ready", 64'(REQ_READY), 64'(1));
  endtask

  task automatic run(input logic [1:0] op, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                     input logic [AW-1:0] w, input logic [DW-1:0] d, input int stall,
                     input bit early);
    present(op, r1, r2, w, d, early);
    accept_and_wait();
    release_rsp(early ? 0 : stall);
  endtask

  task automatic preload();
    for (int i = 0; i < int'(NREG); i++)
      run(2'b01, '0, '0, AW'(i), $urandom() | 32'h1, 0, 1'b0);
  endtask

  task automatic sweep();
    for (int i = 0; i < int'(NREG); i += 2)
      run(2'b00, AW'(i), AW'(i + 1), '0, '0, 0, 1'b0);
  endtask

  initial begin
    RST = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b0; REQ_OP = '0;
    REQ_ADDR_R1 = '0; REQ_ADDR_R2 = '0; REQ_ADDR_W = '0; REQ_DATA_W = '0;
    exp_r1 = '0; exp_r2 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_req_ready", 64'(REQ_READY), 64'(1));
    check_eq("rst_rsp_valid", 64'(RSP_VALID), 64'(0));
    check_eq("rst_strobes", 64'({RF_READ, RF_WRITE}), 64'(0));
    check_eq("rst_addrs", 64'({RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W}), 64'(0));
    check_eq("rst_data_w", 64'(RF_DATA_W), 64'(0));
    check_eq("rst_rsp_data", 64'({RSP_DATA_R1, RSP_DATA_R2}), 64'(0));
    RST = 1'b1;
    rq.delete(); wq.delete();

    preload();

    // Write then read back.
    run(2'b01, '0, '0, 5'd5, 32'hDEADBEEF, 0, 1'b0);
    run(2'b00, 5'd5, 5'd0, '0, '0, 0, 1'b0);
    check_eq("wr_rd_value", 64'(RSP_DATA_R1), 64'(32'hDEADBEEF));

    // Read-then-write on the same register returns the old value.
    run(2'b01, '0, '0, 5'd7, 32'h11111111, 0, 1'b0);
    run(2'b10, 5'd7, 5'd3, 5'd7, 32'h22222222, 0, 1'b0);
    check_eq("rw_old_value", 64'(RSP_DATA_R1), 64'(32'h11111111));
    run(2'b00, 5'd7, 5'd7, '0, '0, 0, 1'b0);
    check_eq("rw_new_value", 64'(RSP_DATA_R1), 64'(32'h22222222));

    // Backpressure with the next request already presented.
    present(2'b00, 5'd5, 5'd7, '0, '0, 1'b0);
    accept_and_wait();
    present(2'b01, '0, '0, 5'd9, 32'hCAFEF00D, 1'b0);
    release_rsp(5);
    accept_and_wait();
    release_rsp(0);

    // Clear with every register nonzero.
    preload();
    run(2'b11, '0, '0, '0, '0, 0, 1'b0);
    sweep();

    // Reset in the middle of a clear.
    preload();
    present(2'b11, '0, '0, '0, '0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    repeat (9) begin @(posedge CLK); @(negedge CLK); end
    RST = 1'b0;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b1;
    check_eq("midclr_req_ready", 64'(REQ_READY), 64'(1));
    check_eq("midclr_rf_write", 64'(RF_WRITE), 64'(0));
    check_eq("midclr_rsp_valid", 64'(RSP_VALID), 64'(0));
    check_eq("midclr_rsp_data", 64'(RSP_DATA_R1), 64'(0));
    check_eq("midclr_writes", 64'(wq.size()), 64'(10));
    for (int i = 0; i < 10; i++) ref_mem[i] = '0;
    exp_r1 = '0; exp_r2 = '0;
    rq.delete(); wq.delete();
    sweep();

    // Random op mix.
    for (int n = 0; n < 1000; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11 && $urandom_range(0, 3) != 0) op = 2'b10;
      run(op, AW'($urandom()), AW'($urandom()), AW'($urandom()), $urandom(),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
